// File: rtl/systolic_array_ctrl_if.sv
// Control/handshake bundle between the tile sequencer and its scheduler, buffers, array and output buffer.
interface systolic_array_ctrl_if #(
   parameter int unsigned DIM = 32,
   parameter int unsigned AW  = 8
);
   localparam int unsigned WW = (DIM > 1) ? $clog2(DIM) : 1;

   logic          start_i;
   logic          reuse_weights_i;
   logic [AW:0]   num_rows_i;
   logic          stall_req_i;
   logic          busy_o;
   logic          done_o;
   logic          w_rd_en_o;
   logic [WW-1:0] w_rd_addr_o;
   logic          a_rd_en_o;
   logic [AW-1:0] a_rd_addr_o;
   logic          load_weights_o;
   logic          compute_o;
   logic          stall_o;
   logic          act_zero_o;
   logic          out_valid_o;
   logic [AW-1:0] out_wr_addr_o;

   modport master (
      input  start_i, reuse_weights_i, num_rows_i, stall_req_i,
      output busy_o, done_o, w_rd_en_o, w_rd_addr_o, a_rd_en_o, a_rd_addr_o,
             load_weights_o, compute_o, stall_o, act_zero_o, out_valid_o, out_wr_addr_o
   );

   modport slave (
      output start_i, reuse_weights_i, num_rows_i, stall_req_i,
      input  busy_o, done_o, w_rd_en_o, w_rd_addr_o, a_rd_en_o, a_rd_addr_o,
             load_weights_o, compute_o, stall_o, act_zero_o, out_valid_o, out_wr_addr_o
   );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Sequencer for one tile pass of a weight-stationary systolic array:
// weight load, activation stream, drain, and result-row tagging.
module systolic_array_ctrl #(
   parameter int unsigned DIM      = 32,
   parameter int unsigned MAX_ROWS = 256,
   parameter int unsigned LAT      = 64,
   parameter int unsigned AW       = 8
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   systolic_array_ctrl_if.master bus
);
   localparam int unsigned WW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_W, S_COMPUTE, S_DRAIN, S_DONE
   } state_e;

   state_e         state_q;
   logic [WW-1:0]  w_addr_q;
   logic           w_rd_en_q;
   logic           ld_q;
   logic [CW-1:0]  a_cnt_q;
   logic [CW-1:0]  rows_q;
   logic           a_rd_en_q;
   logic           cp_q;
   logic [LAT-1:0] vpipe_q;
   logic [AW-1:0]  out_addr_q;

   logic           stall;
   logic [CW-1:0]  rows_clamped;

   assign stall        = bus.stall_req_i;
   assign rows_clamped = (bus.num_rows_i > CW'(MAX_ROWS)) ? CW'(MAX_ROWS) : bus.num_rows_i;

   // ld_q/cp_q are the one-cycle read-latency delay regs; they hold across a stall and replay on release
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         w_addr_q   <= '0;
         w_rd_en_q  <= 1'b0;
         ld_q       <= 1'b0;
         a_cnt_q    <= '0;
         rows_q     <= '0;
         a_rd_en_q  <= 1'b0;
         cp_q       <= 1'b0;
         vpipe_q    <= '0;
         out_addr_q <= '0;
      end else begin
         if (!stall) begin
            ld_q    <= w_rd_en_q;
            cp_q    <= a_rd_en_q;
            vpipe_q <= {vpipe_q[LAT-2:0], cp_q};
            if (vpipe_q[LAT-1]) out_addr_q <= out_addr_q + 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (bus.start_i) begin
                  rows_q     <= rows_clamped;
                  w_addr_q   <= '0;
                  a_cnt_q    <= '0;
                  out_addr_q <= '0;
                  if (!bus.reuse_weights_i) begin
                     state_q   <= S_LOAD_W;
                     w_rd_en_q <= 1'b1;
                  end else if (rows_clamped == '0) begin
                     state_q <= S_DONE;
                  end else begin
                     state_q   <= S_COMPUTE;
                     a_rd_en_q <= 1'b1;
                  end
               end
            end
            S_LOAD_W: begin
               if (!stall) begin
                  if (w_rd_en_q) begin
                     w_addr_q <= w_addr_q + 1'b1;
                     if (w_addr_q == WW'(DIM - 1)) begin
                        w_rd_en_q <= 1'b0;
                        if (rows_q != '0) begin
                           state_q   <= S_COMPUTE;
                           a_rd_en_q <= 1'b1;
                        end
                     end
                  end else begin
                     // zero-row pass: the last load_weights cycle has just completed
                     state_q <= S_DONE;
                  end
               end
            end
            S_COMPUTE: begin
               if (!stall && a_rd_en_q) begin
                  a_cnt_q <= a_cnt_q + 1'b1;
                  if (a_cnt_q == rows_q - CW'(1)) begin
                     a_rd_en_q <= 1'b0;
                     state_q   <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (!stall && !cp_q && (vpipe_q == '0)) state_q <= S_DONE;
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy_o         = (state_q != S_IDLE);
   assign bus.done_o         = (state_q == S_DONE);
   assign bus.w_rd_en_o      = w_rd_en_q & ~stall;
   assign bus.w_rd_addr_o    = w_addr_q;
   assign bus.a_rd_en_o      = a_rd_en_q & ~stall;
   assign bus.a_rd_addr_o    = a_cnt_q[AW-1:0];
   assign bus.load_weights_o = ld_q & ~stall;
   // drain keeps the array clocking with zeroed activations once the last real vector has entered
   assign bus.compute_o      = (cp_q | (state_q == S_DRAIN)) & ~stall;
   assign bus.act_zero_o     = (state_q == S_DRAIN) & ~cp_q;
   assign bus.stall_o        = stall;
   assign bus.out_valid_o    = vpipe_q[LAT-1] & ~stall;
   assign bus.out_wr_addr_o  = out_addr_q;
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl: cycle-indexed event capture per pass, compared to hand-derived timing.
module tb_systolic_array_ctrl;
   localparam int unsigned DIM = 32;
   localparam int unsigned AW  = 8;
   localparam int unsigned CW  = AW + 1;

   logic clk_i;
   logic rst_ni;

   systolic_array_ctrl_if #(.DIM(DIM), .AW(AW)) bus ();

   systolic_array_ctrl #(.DIM(DIM), .MAX_ROWS(256), .LAT(64), .AW(AW)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   int w_cnt, w_first, w_bad, ld_cnt, ld_first;
   int a_cnt, a_first, a_bad, cp_cnt, cp_first;
   int v_cnt, v_first, v_bad, done_cnt, done_cyc, idle_cyc, leak;

   // one clock: inputs change just after the rising edge, outputs sampled on the falling edge
   task automatic step(input logic st, input logic sr);
      @(posedge clk_i);
      #1;
      bus.start_i     = st;
      bus.stall_req_i = sr;
      @(negedge clk_i);
   endtask

   // start a pass at cycle 0 and record when/what each output does until busy_o drops
   task automatic run_pass(input logic reuse, input int rows, input int s0, input int s0len,
                           input int s1, input int s1len, input int restart_cyc, input int budget);
      logic sr;
      w_cnt = 0; w_first = -1; w_bad = 0; ld_cnt = 0; ld_first = -1;
      a_cnt = 0; a_first = -1; a_bad = 0; cp_cnt = 0; cp_first = -1;
      v_cnt = 0; v_first = -1; v_bad = 0; done_cnt = 0; done_cyc = -1; idle_cyc = -1; leak = 0;
      bus.reuse_weights_i = reuse;
      bus.num_rows_i      = CW'(rows);
      for (int cyc = 0; cyc <= budget; cyc++) begin
         sr = ((cyc >= s0) && (cyc < s0 + s0len)) || ((cyc >= s1) && (cyc < s1 + s1len));
         step((cyc == 0) || (cyc == restart_cyc), sr);
         if (cyc >= 1 && !bus.busy_o) begin
            idle_cyc = cyc;
            break;
         end
         if (bus.w_rd_en_o) begin
            if (w_first < 0) w_first = cyc;
            if (int'(bus.w_rd_addr_o) != w_cnt) w_bad++;
            w_cnt++;
         end
         if (bus.load_weights_o) begin
            if (ld_first < 0) ld_first = cyc;
            ld_cnt++;
         end
         if (bus.a_rd_en_o) begin
            if (a_first < 0) a_first = cyc;
            if (int'(bus.a_rd_addr_o) != a_cnt) a_bad++;
            a_cnt++;
         end
         if (bus.compute_o && !bus.act_zero_o) begin
            if (cp_first < 0) cp_first = cyc;
            cp_cnt++;
         end
         if (bus.out_valid_o) begin
            if (v_first < 0) v_first = cyc;
            if (int'(bus.out_wr_addr_o) != (v_cnt % 256)) v_bad++;
            v_cnt++;
         end
         if (bus.done_o) begin
            done_cyc = cyc;
            done_cnt++;
         end
         if (sr && (bus.w_rd_en_o || bus.a_rd_en_o || bus.load_weights_o || bus.compute_o)) leak++;
         if (bus.stall_o !== sr) leak++;
      end
   endtask

   task automatic test_reset;
      rst_ni = 1'b0;
      bus.start_i = 1'b0; bus.stall_req_i = 1'b0; bus.reuse_weights_i = 1'b0; bus.num_rows_i = '0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy_o); end
      n_checks++;
      if ({bus.done_o, bus.w_rd_en_o, bus.a_rd_en_o, bus.load_weights_o, bus.compute_o,
           bus.act_zero_o, bus.out_valid_o, bus.w_rd_addr_o, bus.a_rd_addr_o, bus.out_wr_addr_o} !== '0) begin
         n_fail++; $display("FAIL reset_outputs got nonzero exp all 0");
      end
      @(posedge clk_i); #1; rst_ni = 1'b1;
   endtask

   task automatic test_load_compute;
      run_pass(1'b0, 4, -10, 0, -10, 0, -1, 200);
      n_checks++; if (w_first !== 1)   begin n_fail++; $display("FAIL t1_w_first got %0d exp 1", w_first); end
      n_checks++; if (w_cnt !== 32)    begin n_fail++; $display("FAIL t1_w_cnt got %0d exp 32", w_cnt); end
      n_checks++; if (w_bad !== 0)     begin n_fail++; $display("FAIL t1_w_addr_seq got %0d errors exp 0", w_bad); end
      n_checks++; if (ld_first !== 2)  begin n_fail++; $display("FAIL t1_ld_first got %0d exp 2", ld_first); end
      n_checks++; if (ld_cnt !== 32)   begin n_fail++; $display("FAIL t1_ld_cnt got %0d exp 32", ld_cnt); end
      n_checks++; if (a_first !== 33 || a_cnt !== 4 || a_bad !== 0)
         begin n_fail++; $display("FAIL t1_act_reads got first %0d cnt %0d bad %0d exp 33 4 0", a_first, a_cnt, a_bad); end
      n_checks++; if (cp_first !== 34 || cp_cnt !== 4)
         begin n_fail++; $display("FAIL t1_compute got first %0d cnt %0d exp 34 4", cp_first, cp_cnt); end
      n_checks++; if (v_first !== 98)  begin n_fail++; $display("FAIL t1_valid_first got %0d exp 98", v_first); end
      n_checks++; if (v_cnt !== 4 || v_bad !== 0)
         begin n_fail++; $display("FAIL t1_valid_rows got cnt %0d bad %0d exp 4 0", v_cnt, v_bad); end
      n_checks++; if (done_cnt !== 1 || done_cyc !== 103)
         begin n_fail++; $display("FAIL t1_done got cnt %0d cyc %0d exp 1 103", done_cnt, done_cyc); end
      n_checks++; if (idle_cyc !== 104) begin n_fail++; $display("FAIL t1_idle got %0d exp 104", idle_cyc); end
   endtask

   task automatic test_full_reuse;
      run_pass(1'b1, 256, -10, 0, -10, 0, -1, 400);
      n_checks++; if (w_cnt !== 0 || ld_cnt !== 0)
         begin n_fail++; $display("FAIL t2_no_weights got w %0d ld %0d exp 0 0", w_cnt, ld_cnt); end
      n_checks++; if (a_first !== 1 || a_cnt !== 256 || a_bad !== 0)
         begin n_fail++; $display("FAIL t2_act_reads got first %0d cnt %0d bad %0d exp 1 256 0", a_first, a_cnt, a_bad); end
      n_checks++; if (v_first !== 66 || v_cnt !== 256 || v_bad !== 0)
         begin n_fail++; $display("FAIL t2_valid got first %0d cnt %0d bad %0d exp 66 256 0", v_first, v_cnt, v_bad); end
      n_checks++; if (done_cnt !== 1 || done_cyc !== 323)
         begin n_fail++; $display("FAIL t2_done got cnt %0d cyc %0d exp 1 323", done_cnt, done_cyc); end
   endtask

   task automatic test_stall;
      run_pass(1'b0, 8, 10, 3, 38, 2, -1, 250);
      n_checks++; if (w_cnt !== 32 || w_bad !== 0 || ld_cnt !== 32)
         begin n_fail++; $display("FAIL t3_weights got w %0d bad %0d ld %0d exp 32 0 32", w_cnt, w_bad, ld_cnt); end
      n_checks++; if (a_first !== 36 || a_cnt !== 8 || a_bad !== 0)
         begin n_fail++; $display("FAIL t3_act_reads got first %0d cnt %0d bad %0d exp 36 8 0", a_first, a_cnt, a_bad); end
      n_checks++; if (cp_first !== 37 || cp_cnt !== 8)
         begin n_fail++; $display("FAIL t3_compute got first %0d cnt %0d exp 37 8", cp_first, cp_cnt); end
      n_checks++; if (v_first !== 103 || v_cnt !== 8 || v_bad !== 0)
         begin n_fail++; $display("FAIL t3_valid got first %0d cnt %0d bad %0d exp 103 8 0", v_first, v_cnt, v_bad); end
      n_checks++; if (done_cyc !== 112 || done_cnt !== 1)
         begin n_fail++; $display("FAIL t3_done got cyc %0d cnt %0d exp 112 1", done_cyc, done_cnt); end
      n_checks++; if (leak !== 0) begin n_fail++; $display("FAIL t3_stall_gating got %0d violations exp 0", leak); end
   endtask

   task automatic test_zero_rows;
      run_pass(1'b1, 0, -10, 0, -10, 0, -1, 50);
      n_checks++; if (done_cyc !== 1 || done_cnt !== 1 || idle_cyc !== 2)
         begin n_fail++; $display("FAIL t4_reuse_done got cyc %0d cnt %0d idle %0d exp 1 1 2", done_cyc, done_cnt, idle_cyc); end
      n_checks++; if (w_cnt + a_cnt + v_cnt + cp_cnt !== 0)
         begin n_fail++; $display("FAIL t4_reuse_quiet got w %0d a %0d v %0d cp %0d exp all 0", w_cnt, a_cnt, v_cnt, cp_cnt); end
      run_pass(1'b0, 0, -10, 0, -10, 0, -1, 100);
      n_checks++; if (w_cnt !== 32 || ld_cnt !== 32 || w_bad !== 0)
         begin n_fail++; $display("FAIL t4_load_only got w %0d ld %0d bad %0d exp 32 32 0", w_cnt, ld_cnt, w_bad); end
      n_checks++; if (done_cyc !== 34 || a_cnt !== 0 || v_cnt !== 0)
         begin n_fail++; $display("FAIL t4_load_done got cyc %0d a %0d v %0d exp 34 0 0", done_cyc, a_cnt, v_cnt); end
   endtask

   task automatic test_clamp;
      run_pass(1'b1, 300, -10, 0, -10, 0, -1, 400);
      n_checks++; if (a_cnt !== 256 || v_cnt !== 256 || done_cyc !== 323)
         begin n_fail++; $display("FAIL clamp got a %0d v %0d done %0d exp 256 256 323", a_cnt, v_cnt, done_cyc); end
   endtask

   task automatic test_restart_ignored;
      run_pass(1'b1, 4, -10, 0, -10, 0, 3, 150);
      n_checks++; if (done_cnt !== 1 || done_cyc !== 71)
         begin n_fail++; $display("FAIL t5_restart_done got cnt %0d cyc %0d exp 1 71", done_cnt, done_cyc); end
      n_checks++; if (a_first !== 1 || a_cnt !== 4 || a_bad !== 0 || v_cnt !== 4)
         begin n_fail++; $display("FAIL t5_restart_reads got first %0d a %0d bad %0d v %0d exp 1 4 0 4", a_first, a_cnt, a_bad, v_cnt); end
   endtask

   task automatic test_reset_in_drain;
      int dn;
      dn = 0;
      bus.reuse_weights_i = 1'b1;
      bus.num_rows_i      = CW'(4);
      step(1'b1, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         step(1'b0, 1'b0);
         if (bus.done_o) dn++;
      end
      n_checks++; if (bus.act_zero_o !== 1'b1 || bus.compute_o !== 1'b1)
         begin n_fail++; $display("FAIL t5_in_drain got act_zero %b compute %b exp 1 1", bus.act_zero_o, bus.compute_o); end
      rst_ni = 1'b0;
      #1;
      n_checks++;
      if ({bus.busy_o, bus.done_o, bus.w_rd_en_o, bus.a_rd_en_o, bus.load_weights_o, bus.compute_o,
           bus.act_zero_o, bus.out_valid_o, bus.w_rd_addr_o, bus.a_rd_addr_o, bus.out_wr_addr_o} !== '0 || dn !== 0) begin
         n_fail++; $display("FAIL t5_reset_abort got busy %b compute %b done_seen %0d exp 0 0 0", bus.busy_o, bus.compute_o, dn);
      end
      repeat (2) @(posedge clk_i);
      #1; rst_ni = 1'b1;
      run_pass(1'b0, 2, -10, 0, -10, 0, -1, 200);
      n_checks++; if (w_first !== 1 || w_bad !== 0 || a_bad !== 0 || v_bad !== 0)
         begin n_fail++; $display("FAIL t5_clean_addrs got wfirst %0d wbad %0d abad %0d vbad %0d exp 1 0 0 0", w_first, w_bad, a_bad, v_bad); end
      n_checks++; if (v_first !== 98 || v_cnt !== 2 || done_cyc !== 101 || done_cnt !== 1)
         begin n_fail++; $display("FAIL t5_clean_pass got vfirst %0d v %0d done %0d cnt %0d exp 98 2 101 1", v_first, v_cnt, done_cyc, done_cnt); end
   endtask

   initial begin
      test_reset();
      test_load_compute();
      test_full_reuse();
      test_stall();
      test_zero_rows();
      test_clamp();
      test_restart_ignored();
      test_reset_in_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
